debounce_sync: RTL

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

---
 rtl/debounce_pkg.sv | 23 ++
 rtl/sync_chain.sv | 25 ++
 rtl/debounce_sync.sv | 128 ++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce/synchronizer block: FSM state
// encoding, default parameter values and a small state-decode helper.
package debounce_pkg;

  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned CNT_W_DEF         = 4;
  localparam int unsigned STABLE_CYCLES_DEF = 8;

  // Two idle states remember the committed level; two check states
  // qualify a candidate change towards the opposite level.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } deb_state_e;

  // True while a candidate level change is being qualified.
  function automatic logic is_chk(input deb_state_e st);
    return (st == CHK_HIGH) || (st == CHK_LOW);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level. The first
// stage samples the raw input; q is the last stage.
module sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage_r;

  // Shift the raw level through the chain; reset clears every stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_r <= {DEPTH{1'b0}};
    end else begin
      stage_r <= {stage_r[DEPTH-2:0], d};
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/debounce_sync.sv
// Debounce filter: synchronizes a raw level, then commits a new output
// level only after it has been seen STABLE_CYCLES consecutive cycles
// while enabled. rise/fall pulse for one cycle on each commit; busy
// flags an ongoing qualification. All outputs are registered.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic a,
  output logic out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_s;
  deb_state_e       state_r;
  deb_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             out_r;
  logic             out_nxt_s;
  logic             rise_r;
  logic             rise_nxt_s;
  logic             fall_r;
  logic             fall_nxt_s;
  logic             busy_r;
  logic             busy_nxt_s;

  sync_chain #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (a),
    .q     (sync_s)
  );

  // Next-state, counter and registered-output decode for the qualifier.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = CNT_ZERO;
    out_nxt_s   = out_r;
    rise_nxt_s  = 1'b0;
    fall_nxt_s  = 1'b0;
    case (state_r)
      IDLE_LOW: begin
        if (en && sync_s) begin
          state_nxt_s = CHK_HIGH;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          state_nxt_s = IDLE_LOW;
        end
      end
      CHK_HIGH: begin
        if (!en || !sync_s) begin
          // Abort: fall back to the idle state of the committed level.
          state_nxt_s = out_r ? IDLE_HIGH : IDLE_LOW;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = IDLE_HIGH;
          out_nxt_s   = 1'b1;
          rise_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (en && !sync_s) begin
          state_nxt_s = CHK_LOW;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          state_nxt_s = IDLE_HIGH;
        end
      end
      CHK_LOW: begin
        if (!en || sync_s) begin
          state_nxt_s = out_r ? IDLE_HIGH : IDLE_LOW;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = IDLE_LOW;
          out_nxt_s   = 1'b0;
          fall_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE_LOW;
        out_nxt_s   = 1'b0;
      end
    endcase
    busy_nxt_s = is_chk(state_nxt_s);
  end

  // State, counter and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE_LOW;
      cnt_r   <= CNT_ZERO;
      out_r   <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      out_r   <= out_nxt_s;
      rise_r  <= rise_nxt_s;
      fall_r  <= fall_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign out  = out_r;
  assign rise = rise_r;
  assign fall = fall_r;
  assign busy = busy_r;

endmodule
